nios_button_pio: RTL and testbench

Avalon-MM slave input port for the Nios II system: the read-side counterpart of the LED output ports. Samples an external bus (push buttons/switches) through a synchronizer, exposes the level as a readable data register, latches selected edges into a sticky edge-capture register, and raises a level interrupt to the CPU for unmasked captured edges. Sits between the board pins and the Nios data master on the system interconnect.

---
 rtl/nios_pio_pkg.sv | 33 +++
 rtl/nios_button_pio_if.sv | 19 +
 rtl/nios_pio_sync_debounce.sv | 60 ++++++
 rtl/nios_button_pio.sv | 91 +++++++++
 tb/tb_nios_button_pio.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/nios_pio_pkg.sv
// Shared definitions for the Nios button/switch PIO: register map, edge-type
// encodings and the edge-detect helper used by the top level.
package nios_pio_pkg;

  localparam int unsigned BUS_W = 32;

  typedef enum logic [1:0] {
    ADDR_DATA     = 2'd0,
    ADDR_RSVD     = 2'd1,
    ADDR_IRQ_MASK = 2'd2,
    ADDR_EDGE_CAP = 2'd3
  } reg_addr_e;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

  // Any encoding outside rise/fall is treated as "any edge".
  function automatic logic [BUS_W-1:0] edge_detect(
    input logic [BUS_W-1:0] cur,
    input logic [BUS_W-1:0] prev,
    input edge_type_e       et
  );
    case (et)
      EDGE_RISE: return cur & ~prev;
      EDGE_FALL: return ~cur & prev;
      default:   return cur ^ prev;
    endcase
  endfunction

endpackage

// File: rtl/nios_button_pio_if.sv
// Avalon-MM slave register interface of the button PIO (zero wait states,
// combinational readdata).
interface nios_button_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/nios_pio_sync_debounce.sv
// One input bit: 2-flop synchronizer, optionally followed by a debounce filter
// (compiled in when NIOS_BUTTON_PIO_DEBOUNCE_EN is defined).
module nios_pio_sync_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic level_o
);

  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef NIOS_BUTTON_PIO_DEBOUNCE_EN
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;

  // cnt_q counts consecutive mismatching cycles already seen; the flip happens
  // on the DEBOUNCE_CYCLES-th one.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign level_o = filt_q;
`else
  assign level_o = sync2_q;
`endif

endmodule

// File: rtl/nios_button_pio.sv
// Avalon-MM button/switch input PIO: synced level register, sticky RW1C edge
// capture, irq mask. Optional debounce via NIOS_BUTTON_PIO_DEBOUNCE_EN.
module nios_button_pio
  import nios_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned EDGE_TYPE       = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in_port,
  nios_button_pio_if.slave   avs,
  output logic               irq
);

  localparam edge_type_e EDGE_SEL = edge_type_e'(EDGE_TYPE[1:0]);

  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] edges;
  logic [1:0]       arm_q, arm_d;
  logic             armed;
  logic             wr_en;
  reg_addr_e        addr;
  logic [31:0]      rdata;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nios_pio_sync_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sync (
      .clk     (clk),
      .reset   (reset),
      .async_i (in_port[i]),
      .level_o (level[i])
    );
  end

  assign addr         = reg_addr_e'(avs.address);
  assign wr_en        = avs.chipselect & ~avs.write_n;
  assign armed        = (arm_q == 2'd3);
  assign edges        = WIDTH'(edge_detect(BUS_W'(level), BUS_W'(prev_q), EDGE_SEL));
  assign unused_wdata = ^avs.writedata;

  // Clear is applied before set so a same-cycle edge keeps the bit at 1.
  always_comb begin
    arm_d  = armed ? arm_q : arm_q + 2'd1;
    mask_d = mask_q;
    cap_d  = cap_q;
    if (wr_en && addr == ADDR_IRQ_MASK) begin
      mask_d = avs.writedata[WIDTH-1:0];
    end
    if (wr_en && addr == ADDR_EDGE_CAP) begin
      cap_d = cap_q & ~avs.writedata[WIDTH-1:0];
    end
    if (armed) begin
      cap_d = cap_d | edges;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
      mask_q <= '0;
      cap_q  <= '0;
      arm_q  <= '0;
    end else begin
      prev_q <= level;
      mask_q <= mask_d;
      cap_q  <= cap_d;
      arm_q  <= arm_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_DATA:     rdata[WIDTH-1:0] = level;
      ADDR_IRQ_MASK: rdata[WIDTH-1:0] = mask_q;
      ADDR_EDGE_CAP: rdata[WIDTH-1:0] = cap_q;
      default:       rdata = '0;
    endcase
  end

  assign avs.readdata = rdata;
  assign irq          = |(cap_q & mask_q);

endmodule

// File: tb/tb_nios_button_pio.sv
// Self-checking bench for nios_button_pio: directed scenarios plus randomized
// traffic against a history-based reference model.
module tb_nios_button_pio;

  localparam int unsigned W  = 4;
  localparam int unsigned ET = 1;
  localparam int unsigned DC = 16;
`ifdef NIOS_BUTTON_PIO_DEBOUNCE_EN
  localparam int unsigned EXTRA = DC;
  localparam int unsigned CHG_RANGE = 40;
`else
  localparam int unsigned EXTRA = 0;
  localparam int unsigned CHG_RANGE = 5;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_port;
  logic         irq;

  nios_button_pio_if bus ();

  nios_button_pio #(
    .WIDTH           (W),
    .EDGE_TYPE       (ET),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_port (in_port),
    .avs     (bus.slave),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model. Index k = clock edges since reset release.
  // syn[k] = synchronized input after edge k (= in_port sampled at edge k-1).
  // lvl[k] = readable DATA level after edge k.
  int           k;
  logic [W-1:0] last_in;
  logic [W-1:0] syn[$];
  logic [W-1:0] lvl[$];
  logic [W-1:0] m_cap;
  logic [W-1:0] m_mask;

  function automatic logic [W-1:0] edge_of(input logic [W-1:0] cur, input logic [W-1:0] prev);
    if (ET == 0) return cur & ~prev;
    else if (ET == 1) return prev & ~cur;
    else return cur ^ prev;
  endfunction

  task automatic model_reset();
    k = 0;
    syn.delete();
    lvl.delete();
    syn.push_back('0);
    lvl.push_back('0);
    m_cap   = '0;
    m_mask  = '0;
    last_in = '0;
  endtask

  task automatic model_edge();
    logic [W-1:0] nl, set, clr;
    logic         wr;
    k++;
    syn.push_back((k >= 2) ? last_in : '0);
    last_in = in_port;
`ifdef NIOS_BUTTON_PIO_DEBOUNCE_EN
    // Level flips once the synced bit disagreed with it for DC straight edges.
    nl = lvl[k-1];
    if (k >= int'(DC)) begin
      for (int b = 0; b < int'(W); b++) begin
        logic flip;
        flip = 1'b1;
        for (int j = k - int'(DC); j <= k - 1; j++) begin
          if (syn[j][b] == lvl[k-1][b]) flip = 1'b0;
        end
        if (flip) nl[b] = ~nl[b];
      end
    end
`else
    nl = syn[k];
`endif
    set = (k >= 4) ? edge_of(lvl[k-1], lvl[k-2]) : '0;
    lvl.push_back(nl);
    wr  = bus.chipselect && !bus.write_n;
    clr = (wr && bus.address == 2'd3) ? bus.writedata[W-1:0] : '0;
    if (wr && bus.address == 2'd2) m_mask = bus.writedata[W-1:0];
    m_cap = (m_cap & ~clr) | set;
  endtask

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(lvl[k]);
      2'd2:    return 32'(m_mask);
      2'd3:    return 32'(m_cap);
      default: return 32'h0;
    endcase
  endfunction

  // One bus cycle: drive, check against model, clock, advance model.
  task automatic cyc(input logic [1:0] a, input logic cs, input logic wn,
                     input logic [31:0] wd, input string tag);
    bus.address    = a;
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.writedata  = wd;
    #1;
    check({tag, "_rd"}, bus.readdata, exp_rd(a));
    check({tag, "_irq"}, 32'(irq), 32'(|(m_cap & m_mask)));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cyc(a, 1'b1, 1'b0, d, "wr");
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(2'd3, 1'b0, 1'b1, 32'h0, "idle");
  endtask

  task automatic peek(input logic [1:0] a, input string tag, input logic [31:0] exp);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    #1;
    check(tag, bus.readdata, exp);
  endtask

  initial begin
    reset          = 1'b1;
    in_port        = '1;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    model_reset();
    peek(2'd0, "in_rst_data", 32'h0);
    check("in_rst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Inputs held high through reset: no spurious capture.
    idle(6 + EXTRA);
    peek(2'd0, "rst_data", 32'hF);
    peek(2'd3, "rst_cap", 32'h0);
    check("rst_irq", 32'(irq), 32'h0);

    // Falling edge on bit 2 with mask 0x4, then RW1C clear.
    wr(2'd2, 32'h4);
    in_port[2] = 1'b0;
    idle(2 + EXTRA);
    peek(2'd0, "b2_data", 32'hB);
    peek(2'd3, "b2_cap_early", 32'h0);
    idle(1);
    peek(2'd3, "b2_cap", 32'h4);
    check("b2_irq", 32'(irq), 32'h1);
    wr(2'd3, 32'h4);
    peek(2'd3, "b2_clr_cap", 32'h0);
    check("b2_clr_irq", 32'(irq), 32'h0);

    // Clear and new edge on bit 0 in the same cycle: set wins.
    wr(2'd2, 32'h1);
    in_port[0] = 1'b0;
    idle(2 + EXTRA);
    wr(2'd3, 32'h1);
    peek(2'd3, "setwin_cap", 32'h1);
    check("setwin_irq", 32'(irq), 32'h1);
    wr(2'd3, 32'h1);
    peek(2'd3, "setwin_clr", 32'h0);

    // Capture while masked, then unmask; reserved and DATA writes ignored.
    wr(2'd2, 32'h0);
    in_port[3] = 1'b0;
    idle(3 + EXTRA);
    check("masked_irq", 32'(irq), 32'h0);
    peek(2'd3, "masked_cap", 32'h8);
    wr(2'd2, 32'h8);
    check("unmask_irq", 32'(irq), 32'h1);
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'hFFFF_FFFF);
    peek(2'd0, "ro_data", 32'h2);
    peek(2'd1, "rsvd", 32'h0);

`ifdef NIOS_BUTTON_PIO_DEBOUNCE_EN
    in_port[1] = 1'b0;
    idle(10);
    in_port[1] = 1'b1;
    idle(EXTRA + 4);
    peek(2'd0, "glitch_data", 32'h2);
    peek(2'd3, "glitch_cap", 32'h8);
    in_port[1] = 1'b0;
    idle(1 + DC);
    peek(2'd0, "deb_data_early", 32'h2);
    idle(1);
    peek(2'd0, "deb_data", 32'h0);
    peek(2'd3, "deb_cap_early", 32'h8);
    idle(1);
    peek(2'd3, "deb_cap", 32'hA);
`endif

    // Fill capture and mask, then reset without a clock edge.
    in_port = '1;
    idle(3 + EXTRA);
    in_port = '0;
    idle(3 + EXTRA);
    wr(2'd2, 32'hF);
    peek(2'd3, "pre_rst_cap", 32'hF);
    check("pre_rst_irq", 32'(irq), 32'h1);
    reset = 1'b1;
    for (int a = 0; a < 4; a++) peek(2'(a), "mid_rst_rd", 32'h0);
    check("mid_rst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    in_port = 4'($urandom);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      int unsigned op;
      if ($urandom_range(0, CHG_RANGE) == 0) in_port[$urandom_range(0, W-1)] ^= 1'b1;
      op = $urandom_range(0, 9);
      case (op)
        0, 1:    cyc(2'd2, 1'b1, 1'b0, $urandom, "r_mask");
        2, 3:    cyc(2'd3, 1'b1, 1'b0, $urandom, "r_clr");
        4:       cyc(2'($urandom_range(0, 1)), 1'b1, 1'b0, $urandom, "r_ro");
        5:       cyc(2'($urandom_range(0, 3)), 1'b0, 1'b0, $urandom, "r_nocs");
        default: cyc(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1, $urandom, "r_rd");
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
